// File: rtl/c1_bus_sched_if.sv
// Bus bundle for c1_bus_sched: 68k strobe, zone selects, wait codes and acknowledge lines.
// master = the side driving the 68k cycle, slave = the scheduler.
interface c1_bus_sched_if;
    logic nAS;
    logic nROM_ZONE;
    logic nPORT_ZONE;
    logic nCARD_ZONE;
    logic nSROM_ZONE;
    logic nROMWAIT;
    logic nPWAIT1;
    logic nPWAIT0;
    logic PDTACK;
    logic nDTACK;
    logic nBERR;
    logic BUSY;

    modport master (
        output nAS, nROM_ZONE, nPORT_ZONE, nCARD_ZONE, nSROM_ZONE,
        output nROMWAIT, nPWAIT1, nPWAIT0, PDTACK,
        input  nDTACK, nBERR, BUSY
    );

    modport slave (
        input  nAS, nROM_ZONE, nPORT_ZONE, nCARD_ZONE, nSROM_ZONE,
        input  nROMWAIT, nPWAIT1, nPWAIT0, PDTACK,
        output nDTACK, nBERR, BUSY
    );
endinterface

// File: rtl/c1_bus_sched.sv
// 68k bus cycle scheduler: zone decode, wait-state counting, DTACK generation.
// Optional bus-error watchdog enabled by defining C1_BUS_WATCHDOG_EN.
module c1_bus_sched (
    input  logic CLK_68KCLK,
    input  logic nRESET,
    input  logic nAS,
    input  logic nROM_ZONE,
    input  logic nPORT_ZONE,
    input  logic nCARD_ZONE,
    input  logic nSROM_ZONE,
    input  logic nROMWAIT,
    input  logic nPWAIT1,
    input  logic nPWAIT0,
    input  logic PDTACK,
    output logic nDTACK,
    output logic nBERR,
    output logic BUSY
);
    typedef enum logic [2:0] {IDLE, COUNT, PORTRDY, ACK, UNMAPPED} state_t;
    typedef enum logic [1:0] {ZONE_ROM, ZONE_PORT, ZONE_CARD, ZONE_SROM} zone_t;

    state_t      state_reg, state_next;
    zone_t       zone_reg, zone_next;
    logic [2:0]  wait_reg, wait_next;
    logic        ack_reg, ack_next;

    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_reg <= IDLE;
            zone_reg  <= ZONE_ROM;
            wait_reg  <= 3'd0;
            ack_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            zone_reg  <= zone_next;
            wait_reg  <= wait_next;
            ack_reg   <= ack_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        zone_next  = zone_reg;
        wait_next  = wait_reg;
        case (state_reg)
            IDLE: begin
                if (!nAS) begin
                    state_next = COUNT;
                    if (!nROM_ZONE) begin
                        zone_next = ZONE_ROM;
                        wait_next = {2'b00, ~nROMWAIT};
                    end else if (!nPORT_ZONE) begin
                        zone_next = ZONE_PORT;
                        wait_next = 3'd3 - {1'b0, nPWAIT1, nPWAIT0};
                    end else if (!nCARD_ZONE) begin
                        zone_next = ZONE_CARD;
                        wait_next = 3'd2;
                    end else if (!nSROM_ZONE) begin
                        zone_next = ZONE_SROM;
                        wait_next = 3'd0;
                    end else begin
                        state_next = UNMAPPED;
                    end
                end
            end
            COUNT: begin
                if (wait_reg == 3'd0) begin
                    // A port that is already ready skips PORTRDY so it costs no extra edge.
                    if (zone_reg == ZONE_PORT)
                        state_next = PDTACK ? ACK : PORTRDY;
                    else
                        state_next = ACK;
                end else begin
                    wait_next = wait_reg - 3'd1;
                end
            end
            PORTRDY: begin
                if (PDTACK)
                    state_next = ACK;
            end
            ACK, UNMAPPED: state_next = state_reg;
            default: state_next = IDLE;
        endcase
        if ((state_reg != IDLE) && nAS)
            state_next = IDLE;
    end

    assign ack_next = (state_next != ACK);
    assign nDTACK   = ack_reg | nAS;
    assign BUSY     = (state_reg != IDLE);

`ifdef C1_BUS_WATCHDOG_EN
    logic [6:0] wdog_reg, wdog_next;
    logic       berr_reg, berr_next;

    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            wdog_reg <= 7'd0;
            berr_reg <= 1'b1;
        end else begin
            wdog_reg <= wdog_next;
            berr_reg <= berr_next;
        end
    end

    always_comb begin
        wdog_next = wdog_reg;
        berr_next = berr_reg;
        if ((state_reg == IDLE) || (state_next == IDLE) || (state_next == ACK)) begin
            // An acknowledge landing on the same edge as a timeout beats the bus error.
            wdog_next = 7'd0;
            berr_next = 1'b1;
        end else if (nDTACK) begin
            if (wdog_reg < 7'd64)
                wdog_next = wdog_reg + 7'd1;
            if (wdog_next == 7'd64)
                berr_next = 1'b0;
        end
    end

    assign nBERR = berr_reg;
`else
    assign nBERR = 1'b1;
`endif
endmodule
